branch_redirect_unit: RTL and testbench

Sequential control-transfer resolver for the TinyRV1 pipeline, on the consuming end of the 32-bit equality comparator's `eq` flag. Takes the X-stage control instruction (BNE, JAL, JR) with its comparator result and generates a registered PC redirect, a JAL link value and a timed squash of younger F/D instructions. A small state machine enforces the squash window and ignores wrong-path control instructions.

---
 rtl/tinyrv1_br_pkg.sv | 36 +++
 rtl/bru_squash_counter.sv | 38 +++
 rtl/branch_redirect_unit.sv | 153 +++++++++++++++
 tb/tb_branch_redirect_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyrv1_br_pkg.sv
// Shared types and constants for the TinyRV1 branch redirect logic.
// Latency: n/a (types, constants and a pure target helper only).
// Backpressure: n/a.
package tinyrv1_br_pkg;

    // X-stage control-transfer kind; NONE is never accepted
    typedef enum logic [1:0] {
        NONE = 2'd0,
        BNE  = 2'd1,
        JAL  = 2'd2,
        JR   = 2'd3
    } br_type_t;

    // Resolver state: accepting, or inside the squash window
    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } bru_state_t;

    // Link offset written by JAL
    localparam logic [31:0] PC_INCR = 32'd4;

    // JR targets are word aligned; BNE/JAL are pc-relative, both wrap mod 2^32
    function automatic logic [31:0] calc_target(
        input br_type_t    ty,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input logic [31:0] rs1
    );
        if (ty == JR) begin
            return rs1 & 32'hFFFF_FFFC;
        end
        return pc + imm;
    endfunction

endpackage

// File: rtl/bru_squash_counter.sv
// Loadable 3-bit down-counter that times the squash window.
// Latency: load/decrement take effect at the next edge; done reflects the held count.
// Backpressure: none; decrement stops at zero.
module bru_squash_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Load has priority over decrement; hold at zero once drained
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last squash cycle: the decrement happening now ends the window
    assign done = (cnt_q == 3'd1);

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves X-stage BNE/JAL/JR into a registered redirect, JAL link write and timed F/D squash.
// Latency: accept at edge t -> redirect/link pulse in cycle t+1, squash for t+1..t+SQUASH_CYCLES.
// Backpressure: stall_X holds off acceptance; control ops during squash are dropped. Option: BRU_STATS_EN.
module branch_redirect_unit
    import tinyrv1_br_pkg::*;
#(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_val,
    input  logic [1:0]  br_type,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] br_rs1,
    input  logic        br_eq,
    input  logic        stall_X,
    output logic        redirect_val,
    output logic [31:0] redirect_pc,
    output logic        link_val,
    output logic [31:0] link_data,
    output logic        squash_F,
    output logic        squash_D,
`ifdef BRU_STATS_EN
    output logic [31:0] stat_taken,
    output logic [31:0] stat_not_taken,
`endif
    output logic        busy
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    br_type_t   ty;
    bru_state_t state_q;
    bru_state_t state_d;
    logic       accept;
    logic       taken;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_done;
    logic [31:0] target;

    logic        redirect_val_q;
    logic [31:0] redirect_pc_q;
    logic        link_val_q;
    logic [31:0] link_data_q;

    assign ty = br_type_t'(br_type);

    // Accept qualification and taken decision for the X-stage instruction
    always_comb begin
        accept = br_val & ~stall_X & (ty != NONE) & (state_q == IDLE);
        taken  = 1'b0;
        case (ty)
            BNE:     taken = ~br_eq;
            JAL:     taken = 1'b1;
            JR:      taken = 1'b1;
            default: taken = 1'b0;
        endcase
        target = calc_target(ty, br_pc, br_imm, br_rs1);
    end

    // Next-state logic: enter SQUASH on a taken accept, leave when the count runs out
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && taken) begin
                    state_d  = SQUASH;
                    cnt_load = 1'b1;
                end
            end
            SQUASH: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset aborts any squash in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    bru_squash_counter u_sq_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SQ_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Registered redirect and link pulses; data holds its last value between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_val_q <= 1'b0;
            redirect_pc_q  <= 32'd0;
            link_val_q     <= 1'b0;
            link_data_q    <= 32'd0;
        end else begin
            redirect_val_q <= accept & taken;
            link_val_q     <= accept & (ty == JAL);
            if (accept && taken) begin
                redirect_pc_q <= target;
            end
            if (accept && (ty == JAL)) begin
                link_data_q <= br_pc + PC_INCR;
            end
        end
    end

    assign redirect_val = redirect_val_q;
    assign redirect_pc  = redirect_pc_q;
    assign link_val     = link_val_q;
    assign link_data    = link_data_q;
    assign busy         = (state_q == SQUASH);
    assign squash_F     = busy;
    assign squash_D     = busy;

`ifdef BRU_STATS_EN
    logic [31:0] stat_taken_q;
    logic [31:0] stat_not_taken_q;

    // Saturating accept counters, split by outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken_q     <= 32'd0;
            stat_not_taken_q <= 32'd0;
        end else if (accept) begin
            if (taken && (stat_taken_q != 32'hFFFF_FFFF)) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
            if (!taken && (stat_not_taken_q != 32'hFFFF_FFFF)) begin
                stat_not_taken_q <= stat_not_taken_q + 32'd1;
            end
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        br_val;
    logic [1:0]  br_type;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic        br_eq;
    logic        stall_X;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        link_val;
    logic [31:0] link_data;
    logic        squash_F;
    logic        squash_D;
    logic        busy;
`ifdef BRU_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
`endif

    int n_vec;
    int n_err;

    branch_redirect_unit #(.SQUASH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_val         (br_val),
        .br_type        (br_type),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .br_rs1         (br_rs1),
        .br_eq          (br_eq),
        .stall_X        (stall_X),
        .redirect_val   (redirect_val),
        .redirect_pc    (redirect_pc),
        .link_val       (link_val),
        .link_data      (link_data),
        .squash_F       (squash_F),
        .squash_D       (squash_D),
`ifdef BRU_STATS_EN
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sit 1ns after it to sample and drive
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_val  = 1'b0;
        br_type = 2'd0;
        br_pc   = 32'd0;
        br_imm  = 32'd0;
        br_rs1  = 32'd0;
        br_eq   = 1'b0;
        stall_X = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        step();
        step();
        n_vec++;
        if ({redirect_val, link_val, squash_F, squash_D, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got %b want 00000", {redirect_val, link_val, squash_F, squash_D, busy});
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if (redirect_pc !== 32'd0 || link_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got pc=%h link=%h want 0/0", redirect_pc, link_data);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_bne_not_taken();
        br_val = 1'b1; br_type = 2'd1; br_pc = 32'h100; br_imm = 32'h20; br_eq = 1'b1;
        step();
        n_vec++;
        if ({redirect_val, link_val, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL bne_nt: got rv/lv/busy=%b want 000", {redirect_val, link_val, busy});
        end
        br_val = 1'b0;
        step();
        n_vec++;
        if ({redirect_val, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL bne_nt_after: got rv/busy=%b want 00", {redirect_val, busy});
        end
    endtask

    task automatic test_bne_taken();
        br_val = 1'b1; br_type = 2'd1; br_pc = 32'h100; br_imm = 32'h20; br_eq = 1'b0;
        step();   // cycle t+1
        n_vec++;
        if (redirect_val !== 1'b1 || redirect_pc !== 32'h120) begin
            n_err++;
            $display("FAIL bne_t_redirect: got v=%b pc=%h want 1/00000120", redirect_val, redirect_pc);
        end
        n_vec++;
        if ({squash_F, squash_D, busy, link_val} !== 4'b1110) begin
            n_err++;
            $display("FAIL bne_t_sq1: got F/D/busy/lv=%b want 1110", {squash_F, squash_D, busy, link_val});
        end
        br_pc = 32'h300;  // wrong-path BNE held during the squash window
        step();   // cycle t+2
        n_vec++;
        if ({redirect_val, squash_F, squash_D, busy} !== 4'b0111) begin
            n_err++;
            $display("FAIL bne_t_sq2: got rv/F/D/busy=%b want 0111", {redirect_val, squash_F, squash_D, busy});
        end
        step();   // cycle t+3: BNE presented at t+2 must have been dropped
        n_vec++;
        if ({redirect_val, squash_F, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL bne_t_end: got rv/F/busy=%b want 000", {redirect_val, squash_F, busy});
        end
        br_val = 1'b0;
        step();
    endtask

    task automatic test_jal_wrap();
        br_val = 1'b1; br_type = 2'd2; br_pc = 32'hFFFF_FFFC; br_imm = 32'd8;
        step();
        br_val = 1'b0;
        n_vec++;
        if (redirect_val !== 1'b1 || redirect_pc !== 32'h4) begin
            n_err++;
            $display("FAIL jal_redirect: got v=%b pc=%h want 1/00000004", redirect_val, redirect_pc);
        end
        n_vec++;
        if (link_val !== 1'b1 || link_data !== 32'h0) begin
            n_err++;
            $display("FAIL jal_link: got v=%b data=%h want 1/00000000", link_val, link_data);
        end
        step();
        n_vec++;
        if ({link_val, redirect_val, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL jal_pulse_len: got lv/rv/busy=%b want 001", {link_val, redirect_val, busy});
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL jal_sq_end: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_jr_stall();
        br_val = 1'b1; br_type = 2'd3; br_rs1 = 32'h203; br_pc = 32'h40; br_imm = 32'h10; stall_X = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if ({redirect_val, busy, link_val} !== 3'b000) begin
                n_err++;
                $display("FAIL jr_stalled%0d: got rv/busy/lv=%b want 000", i, {redirect_val, busy, link_val});
            end
        end
        stall_X = 1'b0;
        step();
        br_val = 1'b0;
        n_vec++;
        if (redirect_val !== 1'b1 || redirect_pc !== 32'h200 || link_val !== 1'b0) begin
            n_err++;
            $display("FAIL jr_redirect: got v=%b pc=%h lv=%b want 1/00000200/0", redirect_val, redirect_pc, link_val);
        end
        step();
        step();
    endtask

    task automatic test_stall_reeval();
        // Stalled while eq=0, released with eq=1: the release-cycle eq decides (not taken)
        br_val = 1'b1; br_type = 2'd1; br_pc = 32'h500; br_imm = 32'h8; br_eq = 1'b0; stall_X = 1'b1;
        step();
        stall_X = 1'b0; br_eq = 1'b1;
        step();
        br_val = 1'b0;
        n_vec++;
        if ({redirect_val, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_reeval: got rv/busy=%b want 00", {redirect_val, busy});
        end
        step();
    endtask

    task automatic test_back_to_back();
        br_val = 1'b1; br_type = 2'd1; br_pc = 32'h1000; br_imm = 32'hFFFF_FFF0; br_eq = 1'b0;
        step();   // t+1
        n_vec++;
        if (redirect_val !== 1'b1 || redirect_pc !== 32'h0FF0) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b pc=%h want 1/00000ff0", redirect_val, redirect_pc);
        end
        br_pc = 32'h2000; br_imm = 32'h4;
        step();   // t+2 (presented here: dropped)
        step();   // t+3 idle, accept at this edge
        n_vec++;
        if ({redirect_val, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_gap: got rv/busy=%b want 00", {redirect_val, busy});
        end
        step();   // t+4
        br_val = 1'b0;
        n_vec++;
        if (redirect_val !== 1'b1 || redirect_pc !== 32'h2004 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b pc=%h busy=%b want 1/00002004/1", redirect_val, redirect_pc, busy);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_squash();
        br_val = 1'b1; br_type = 2'd1; br_pc = 32'h100; br_imm = 32'h20; br_eq = 1'b0;
        step();
        br_val = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: got busy=%b want 1", busy);
        end
`ifdef BRU_STATS_EN
        n_vec++;
        if (stat_taken == 32'd0) begin
            n_err++;
            $display("FAIL stat_taken_pre: got %0d want nonzero", stat_taken);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({squash_F, squash_D, busy, redirect_val} !== 4'b0000 || redirect_pc !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid: got F/D/busy/rv=%b pc=%h want 0000/0", {squash_F, squash_D, busy, redirect_val}, redirect_pc);
        end
`ifdef BRU_STATS_EN
        n_vec++;
        if (stat_taken !== 32'd0 || stat_not_taken !== 32'd0) begin
            n_err++;
            $display("FAIL stat_reset: got %0d/%0d want 0/0", stat_taken, stat_not_taken);
        end
`endif
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_after: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_bne_not_taken();
        test_bne_taken();
        test_jal_wrap();
        test_jr_stall();
        test_stall_reeval();
        test_back_to_back();
        test_reset_mid_squash();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
